// File: rtl/inst_fetch_pkg.sv
// Shared widths, stall encoding and reset PC for the instruction-fetch stage.
package inst_fetch_pkg;

    localparam int StallBus    = 6;
    localparam int IF_TO_ID_WD = 33;
    localparam int BR_WD       = 33;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // One word below the MIPS boot vector, so the first fetch after reset
    // lands on 32'hBFC0_0000.
    localparam logic [31:0] RESET_PC_M4 = 32'hBFBF_FFFC;

    // Split the decode-stage redirect bus into its enable and target.
    function automatic logic br_enable(input logic [BR_WD-1:0] bus);
        return bus[BR_WD-1];
    endfunction

    function automatic logic [31:0] br_target(input logic [BR_WD-1:0] bus);
        return bus[31:0];
    endfunction

endpackage

// File: rtl/inst_fetch_redirect_buf.sv
// One-entry buffer that holds a branch/jump target which arrived while the PC
// was frozen, so the redirect survives until the stall releases.
module redirect_buf
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture_i,   // load target into an empty entry
    input  logic        overwrite_i, // replace the target of a valid entry
    input  logic        clear_i,     // PC advanced; the entry has been consumed
    input  logic [31:0] addr_i,
    output logic        pend_v_o,
    output logic [31:0] pend_addr_o
);

    logic        pend_v_q;
    logic [31:0] pend_addr_q;

    // Entry update: clear wins over any load in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, regardless of statement order.
        if (rst) begin
            pend_v_q    <= 1'b0;
            // NOTE: the address is reset too although pend_v qualifies it;
            // a single 32-bit register is cheap and keeps traces clean.
            pend_addr_q <= 32'h0;
        end else if (clear_i) begin
            pend_v_q    <= 1'b0;
        end else if (capture_i || overwrite_i) begin
            pend_v_q    <= 1'b1;
            pend_addr_q <= addr_i;
        end
    end

    assign pend_v_o    = pend_v_q;
    assign pend_addr_o = pend_addr_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM read port
// and forwards {ce, pc} to decode. Decode redirects arrive on br_bus; the
// instruction in the delay slot is never squashed.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [StallBus-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata
);

    typedef enum logic [1:0] {
        IDLE,    // reset cycle, nothing fetched yet
        RUN,     // PC advances every edge
        HOLD,    // PC frozen, no redirect waiting
        HOLD_BR  // PC frozen, redirect waiting in the buffer
    } state_e;

    state_e      state;
    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] next_pc;
    logic        pend_v;
    logic [31:0] pend_addr;
    logic        buf_capture, buf_overwrite, buf_clear;
    logic        unused_stall;

    assign br_e         = br_enable(br_bus);
    assign br_addr      = br_target(br_bus);
    // Only bit 0 concerns this stage; the rest belong to later stages.
    assign unused_stall = ^stall[StallBus-1:1];

    // Live redirect beats a buffered one, which beats sequential fetch.
    assign next_pc = br_e   ? br_addr   :
                     pend_v ? pend_addr :
                              pc_q + 32'd4;

    // State is a pure decode of the registers and the stall input.
    always_comb begin
        if (!ce_q)                   state = IDLE;
        else if (stall[0] == NoStop) state = RUN;
        else if (pend_v)             state = HOLD_BR;
        else                         state = HOLD;
    end

    // Next PC and redirect-buffer controls for the current state.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a
        // signal unassigned and no latch is inferred.
        pc_d          = pc_q;
        ce_d          = ce_q;
        buf_capture   = 1'b0;
        buf_overwrite = 1'b0;
        buf_clear     = 1'b0;
        unique case (state)
            IDLE, RUN: begin
                pc_d      = next_pc;
                ce_d      = 1'b1;
                buf_clear = 1'b1;
            end
            HOLD:    buf_capture   = br_e;
            HOLD_BR: buf_overwrite = br_e;
            default: ;
        endcase
    end

    // PC and chip-enable registers; these drive the SRAM port directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC_M4;
            ce_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            ce_q <= ce_d;
        end
    end

    redirect_buf u_redirect_buf (
        .clk         (clk),
        .rst         (rst),
        .capture_i   (buf_capture),
        .overwrite_i (buf_overwrite),
        .clear_i     (buf_clear),
        .addr_i      (br_addr),
        .pend_v_o    (pend_v),
        .pend_addr_o (pend_addr)
    );

    assign inst_sram_en    = ce_q;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wdata = 32'h0;
    assign if_to_id_bus    = {ce_q, pc_q};

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset release, branches, stalled redirects,
// overwrite/priority, reset with a pending redirect and PC wrap-around.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [StallBus-1:0]    stall;
    logic [BR_WD-1:0]       br_bus;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata)
    );

    task automatic check(input string tag, input logic [32:0] observed,
                         input logic [32:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle past it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full fetch view: enable, address and the decode bus.
    task automatic expect_fetch(input string tag, input logic en,
                                input logic [31:0] addr);
        check({tag, ".en"},   {32'h0, inst_sram_en}, {32'h0, en});
        check({tag, ".addr"}, {1'b0, inst_sram_addr}, {1'b0, addr});
        check({tag, ".bus"},  if_to_id_bus, {en, addr});
    endtask

    initial begin
        rst    = 1'b1;
        stall  = '0;
        br_bus = '0;

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_fetch("reset", 1'b0, 32'hBFBF_FFFC);
        end
        check("wen",   {29'h0, inst_sram_wen}, 33'h0);
        check("wdata", {1'b0, inst_sram_wdata}, 33'h0);

        // Release: sequential fetch from the boot vector.
        rst = 1'b0;
        tick(); expect_fetch("boot0", 1'b1, 32'hBFC0_0000);
        tick(); expect_fetch("boot1", 1'b1, 32'hBFC0_0004);
        tick(); expect_fetch("boot2", 1'b1, 32'hBFC0_0008);
        tick(); expect_fetch("seq3",  1'b1, 32'hBFC0_000C);
        tick(); expect_fetch("seq4",  1'b1, 32'hBFC0_0010);

        // Unstalled branch: one-edge redirect.
        br_bus = {1'b1, 32'hBFC0_0100};
        tick(); expect_fetch("br_tgt", 1'b1, 32'hBFC0_0100);
        br_bus = '0;
        tick(); expect_fetch("br_seq", 1'b1, 32'hBFC0_0104);

        // Redirect in the first cycle of a 3-cycle stall.
        stall  = 6'b000011;
        br_bus = {1'b1, 32'hBFC0_0200};
        tick(); expect_fetch("stall0", 1'b1, 32'hBFC0_0104);
        br_bus = '0;
        tick(); expect_fetch("stall1", 1'b1, 32'hBFC0_0104);
        tick(); expect_fetch("stall2", 1'b1, 32'hBFC0_0104);
        stall = '0;
        tick(); expect_fetch("pend_tgt", 1'b1, 32'hBFC0_0200);
        tick(); expect_fetch("pend_seq", 1'b1, 32'hBFC0_0204);

        // Overwrite while stalled, then a live redirect at release wins.
        stall  = 6'b000001;
        br_bus = {1'b1, 32'h0000_0300};
        tick(); expect_fetch("ovw0", 1'b1, 32'hBFC0_0204);
        br_bus = {1'b1, 32'h0000_0400};
        tick(); expect_fetch("ovw1", 1'b1, 32'hBFC0_0204);
        br_bus = '0;
        tick(); expect_fetch("ovw2", 1'b1, 32'hBFC0_0204);
        stall  = '0;
        br_bus = {1'b1, 32'h0000_0500};
        tick(); expect_fetch("live_win", 1'b1, 32'h0000_0500);
        br_bus = '0;
        // A stale entry would steer this fetch to 0x400.
        tick(); expect_fetch("pend_clr", 1'b1, 32'h0000_0504);

        // Reset mid-stall with a redirect pending.
        stall  = 6'b000001;
        br_bus = {1'b1, 32'h0000_0600};
        tick(); expect_fetch("rs_hold", 1'b1, 32'h0000_0504);
        br_bus = '0;
        rst    = 1'b1;
        tick(); expect_fetch("rs_rst", 1'b0, 32'hBFBF_FFFC);
        rst   = 1'b0;
        stall = '0;
        tick(); expect_fetch("rs_boot0", 1'b1, 32'hBFC0_0000);
        tick(); expect_fetch("rs_boot1", 1'b1, 32'hBFC0_0004);

        // Wrap-around at the top of the address space.
        br_bus = {1'b1, 32'hFFFF_FFFC};
        tick(); expect_fetch("wrap_top", 1'b1, 32'hFFFF_FFFC);
        br_bus = '0;
        tick(); expect_fetch("wrap0", 1'b1, 32'h0000_0000);
        tick(); expect_fetch("wrap4", 1'b1, 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
